// File: rtl/aes_pkg.sv
// Shared AES-128 constants, controller state encoding and GF(2^8) round helpers.
package aes_pkg;

  localparam int unsigned AES_NR       = 10;
  localparam int unsigned AES_BLK_W    = 128;
  localparam int unsigned AES_RK_BUS_W = 1408;
  localparam int unsigned AES_RK_MSB   = AES_RK_BUS_W - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_ctrl_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box from first principles: x^254 is the field inverse (0 maps to 0), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, inv;
    p   = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Byte 4c+r is row r, column c; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input int unsigned j);
    case (j)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_rk_sel.sv
// Selects round key rk[round] from the expanded key bus; out-of-range rounds yield zero.
module aes_rk_sel
  import aes_pkg::*;
(
  input  logic [AES_RK_BUS_W-1:0] round_keys,
  input  logic [3:0]              round,
  output logic [AES_BLK_W-1:0]    rk
);
  always_comb begin
    rk = '0;
    for (int r = 0; r <= int'(AES_NR); r++)
      if (round == 4'(r)) rk = round_keys[AES_RK_MSB-AES_BLK_W*r -: AES_BLK_W];
  end
endmodule

// File: rtl/aes_round_lib.sv
// Combinational AES-128 building blocks: key schedule, full round and final-round pieces.
module Key_Generator
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0]    Key,
  output logic [AES_RK_BUS_W-1:0] RoundKeys
);
  logic [43:0][31:0] w;
  logic [31:0]       t;

  // Standard 44-word expansion; round key r occupies words 4r..4r+3, round 0 at the MSB end.
  always_comb begin
    w = '0;
    t = '0;
    RoundKeys = '0;
    for (int i = 0; i < 4; i++) w[i] = Key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^
            {rcon(32'(i / 4)), 24'h000000};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) RoundKeys[AES_RK_MSB-32*i -: 32] = w[i];
  end
endmodule

module encryptRound
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] din,
  input  logic [AES_BLK_W-1:0] rkey,
  output logic [AES_BLK_W-1:0] dout
);
  assign dout = mix_columns(shift_rows(sub_bytes(din))) ^ rkey;
endmodule

module subBytes
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] din,
  output logic [AES_BLK_W-1:0] dout
);
  assign dout = sub_bytes(din);
endmodule

module Shiftrows
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] din,
  output logic [AES_BLK_W-1:0] dout
);
  assign dout = shift_rows(din);
endmodule

module addRoundKey
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] din,
  input  logic [AES_BLK_W-1:0] rkey,
  output logic [AES_BLK_W-1:0] dout
);
  assign dout = din ^ rkey;
endmodule

// File: rtl/aes_enc_ctrl.sv
// Iterative AES-128 encryption controller sharing one round datapath over rounds 1..10.
// Optional completed-block counter enabled by defining AES_ENC_CTRL_STATS_EN.
module aes_enc_ctrl
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] In,
  input  logic [AES_BLK_W-1:0] Key,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] Out,
  output logic                 busy,
  output logic [3:0]           round,
  output logic [31:0]          blk_cnt
);
  aes_ctrl_state_t          fsm_q;
  logic [AES_BLK_W-1:0]     state_q;
  logic [AES_BLK_W-1:0]     key_q;
  logic [AES_RK_BUS_W-1:0]  round_keys;
  logic [AES_BLK_W-1:0]     rk;
  logic [AES_BLK_W-1:0]     round_out;
  logic [AES_BLK_W-1:0]     sb_out;
  logic [AES_BLK_W-1:0]     sr_out;
  logic [AES_BLK_W-1:0]     final_out;

  Key_Generator u_keygen (.Key(key_q), .RoundKeys(round_keys));
  aes_rk_sel    u_rk_sel (.round_keys(round_keys), .round(round), .rk(rk));
  encryptRound  u_round  (.din(state_q), .rkey(rk), .dout(round_out));
  subBytes      u_sb     (.din(state_q), .dout(sb_out));
  Shiftrows     u_sr     (.din(sb_out), .dout(sr_out));
  addRoundKey   u_ark    (.din(sr_out), .rkey(rk), .dout(final_out));

  // Accept is allowed the first cycle after reset, so ready is decoded from the state register.
  assign in_ready = (fsm_q == IDLE) && !rst;
  assign Out      = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= IDLE;
      state_q   <= '0;
      key_q     <= '0;
      round     <= 4'd0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            key_q   <= Key;
            state_q <= In ^ Key;
            round   <= 4'd1;
            busy    <= 1'b1;
            fsm_q   <= RUN;
          end
        end
        RUN: begin
          if (round == 4'(AES_NR)) begin
            state_q   <= final_out;
            out_valid <= 1'b1;
            fsm_q     <= DONE;
          end else if (round != 4'd0 && round < 4'(AES_NR)) begin
            state_q <= round_out;
            round   <= round + 4'd1;
          end else begin
            round <= 4'd0;
            busy  <= 1'b0;
            fsm_q <= IDLE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            round     <= 4'd0;
            busy      <= 1'b0;
            fsm_q     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          round     <= 4'd0;
          busy      <= 1'b0;
          fsm_q     <= IDLE;
        end
      endcase
    end
  end

`ifdef AES_ENC_CTRL_STATS_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 32'd0;
    else if (fsm_q == DONE && out_valid && out_ready) cnt_q <= cnt_q + 32'd1;
  end

  assign blk_cnt = cnt_q;
`else
  assign blk_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// Directed bench for aes_enc_ctrl: FIPS-197 vectors, back-pressure, back-to-back, mid-run reset.
module tb_aes_enc_ctrl;
  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_blk;
  logic [127:0] key_blk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_blk;
  logic         busy;
  logic [3:0]   round;
  logic [31:0]  blk_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

`ifdef AES_ENC_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_enc_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .In(in_blk), .Key(key_blk), .out_valid(out_valid), .out_ready(out_ready),
    .Out(out_blk), .busy(busy), .round(round), .blk_cnt(blk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_blk();
    return STATS ? 32'(exp_cnt) : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [127:0] pt, input logic [127:0] key, input bit hold);
    in_blk   = pt;
    key_blk  = key;
    in_valid = 1'b1;
    #1;
    chk("accept_in_ready", 128'(in_ready), 128'(1));
    tick();
    if (!hold) in_valid = 1'b0;
    chk("accept_round", 128'(round), 128'(1));
    chk("accept_busy", 128'(busy), 128'(1));
    chk("accept_ready_low", 128'(in_ready), 128'(0));
  endtask

  task automatic run_rounds(input logic [127:0] ct, input string tag);
    for (int k = 2; k <= 10; k++) begin
      tick();
      chk({tag, "_round"}, 128'(round), 128'(k));
      chk({tag, "_early_valid"}, 128'(out_valid), 128'(0));
    end
    tick();
    chk({tag, "_out_valid"}, 128'(out_valid), 128'(1));
    chk({tag, "_ct"}, out_blk, ct);
    chk({tag, "_done_round"}, 128'(round), 128'(10));
  endtask

  task automatic handshake(input string tag);
    tick();
    exp_cnt++;
    chk({tag, "_hs_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_hs_round"}, 128'(round), 128'(0));
    chk({tag, "_hs_busy"}, 128'(busy), 128'(0));
    chk({tag, "_hs_in_ready"}, 128'(in_ready), 128'(1));
    chk({tag, "_blk_cnt"}, 128'(blk_cnt), 128'(exp_blk()));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_blk    = '0;
    key_blk   = '0;
    tick();
    tick();
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out", out_blk, 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_round", 128'(round), 128'(0));
    chk("rst_blk_cnt", 128'(blk_cnt), 128'(0));
    rst = 1'b0;

    accept(B_PT, B_KEY, 1'b0);
    run_rounds(B_CT, "appB");
    handshake("appB");

    accept(C_PT, C_KEY, 1'b0);
    run_rounds(C_CT, "appC");
    handshake("appC");

    // Consumer stalls; stray offers must be ignored while the result is held.
    out_ready = 1'b0;
    accept(C_PT, C_KEY, 1'b0);
    run_rounds(C_CT, "bp");
    for (int i = 0; i < 20; i++) begin
      in_valid = (i % 2 == 0);
      in_blk   = B_PT;
      key_blk  = B_KEY;
      tick();
      chk("bp_hold_out", out_blk, C_CT);
      chk("bp_hold_valid", 128'(out_valid), 128'(1));
      chk("bp_in_ready", 128'(in_ready), 128'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    handshake("bp");

    // Back-to-back with in_valid held: second accept lands 12 cycles after the first.
    accept(B_PT, B_KEY, 1'b1);
    run_rounds(B_CT, "b2b1");
    handshake("b2b1");
    accept(C_PT, C_KEY, 1'b0);
    run_rounds(C_CT, "b2b2");
    handshake("b2b2");

    accept(B_PT, B_KEY, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    chk("mid_round5", 128'(round), 128'(5));
    rst = 1'b1;
    tick();
    exp_cnt = 0;
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_round", 128'(round), 128'(0));
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_in_ready", 128'(in_ready), 128'(0));
    chk("mid_rst_blk_cnt", 128'(blk_cnt), 128'(0));
    rst = 1'b0;
    accept(B_PT, B_KEY, 1'b0);
    run_rounds(B_CT, "post_rst");
    handshake("post_rst");

`ifdef AES_ENC_CTRL_STATS_EN
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    #1;
    exp_cnt = -1;
    chk("wrap_preload", 128'(blk_cnt), 128'(32'hFFFF_FFFF));
    accept(C_PT, C_KEY, 1'b0);
    run_rounds(C_CT, "wrap");
    handshake("wrap");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
